// File: rtl/force_sched_pkg.sv
// Shared types for the force/release window scheduler: controller states
// and the default-width schedule entry layout.
package force_sched_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Entry layout at default widths; the modules rebuild it at their own widths.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] start;
    logic [CNT_W_DEF-1:0] len;
    logic [WIDTH_DEF-1:0] mask;
    logic [WIDTH_DEF-1:0] value;
  } entry_t;

endpackage

// File: rtl/force_sched_entry.sv
// One schedule entry: stores {start, len, mask, value} and reports the
// per-bit force enable/value it would contribute at the queried cycle.
module force_sched_entry #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [WIDTH-1:0] i_value,
  input  logic [CNT_W-1:0] i_cyc,
  output logic [WIDTH-1:0] o_en,
  output logic [WIDTH-1:0] o_val
);

  typedef struct packed {
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] value;
  } ent_t;

  ent_t           r_ent;
  logic [CNT_W:0] w_end;
  logic           w_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent <= '0;
    end else if (i_wr) begin
      r_ent <= '{start: i_start, len: i_len, mask: i_mask, value: i_value};
    end
  end

  // One extra bit on the end so start+len past all-ones stays a long window.
  assign w_end    = {1'b0, r_ent.start} + {1'b0, r_ent.len};
  assign w_active = (r_ent.len != '0) && (i_cyc >= r_ent.start) && ({1'b0, i_cyc} < w_end);
  assign o_en     = w_active ? r_ent.mask : '0;
  assign o_val    = o_en & r_ent.value;

endmodule

// File: rtl/force_window_sched.sv
// Cycle-scheduled force/release controller: runs a cycle counter and forces
// net bits according to DEPTH programmable windows, highest index winning.
module force_window_sched
  import force_sched_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  parameter int  CNT_W = CNT_W_DEF,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic             run,
  input  logic             abort,
  input  logic [CNT_W-1:0] stop_cyc,
  input  logic [WIDTH-1:0] net_i,
  output logic [WIDTH-1:0] net_o,
  output logic [WIDTH-1:0] force_en,
  output logic [WIDTH-1:0] force_val,
  output logic [CNT_W-1:0] cyc,
  output logic             busy,
  output logic             done
);

  state_e                        r_state, w_state_nxt;
  logic [CNT_W-1:0]              r_cyc, w_cyc_nxt;
  logic [WIDTH-1:0]              r_fen, r_fval, w_fen_nxt, w_fval_nxt;
  logic                          w_cfg_wr;
  logic [DEPTH-1:0][WIDTH-1:0]   w_ent_en, w_ent_val;

  assign w_cfg_wr = cfg_valid && cfg_ready;

  // Entries are queried with the next cycle so outputs line up with cyc.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    force_sched_entry #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_cfg_wr && (cfg_idx == IDX_W'(g))),
      .i_start (cfg_start),
      .i_len   (cfg_len),
      .i_mask  (cfg_mask),
      .i_value (cfg_value),
      .i_cyc   (w_cyc_nxt),
      .o_en    (w_ent_en[g]),
      .o_val   (w_ent_val[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_fen   <= '0;
      r_fval  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_fen   <= w_fen_nxt;
      r_fval  <= w_fval_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    unique case (r_state)
      IDLE, DONE: begin
        if (run) begin
          w_state_nxt = RUN;
          w_cyc_nxt   = '0;
        end
      end
      RUN: begin
        if (r_cyc == stop_cyc) w_state_nxt = DONE;
        else if (r_cyc != '1)  w_cyc_nxt   = r_cyc + CNT_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) begin
      w_state_nxt = IDLE;
      w_cyc_nxt   = r_cyc;
    end
  end

  // Later (higher-index) entries overwrite the bits they cover.
  always_comb begin
    w_fen_nxt  = '0;
    w_fval_nxt = '0;
    if (w_state_nxt == RUN) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_fval_nxt = (w_fval_nxt & ~w_ent_en[k]) | w_ent_val[k];
        w_fen_nxt  = w_fen_nxt | w_ent_en[k];
      end
    end
  end

  assign force_en  = r_fen;
  assign force_val = r_fval;
  assign net_o     = r_fval | (net_i & ~r_fen);
  assign cyc       = r_cyc;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign cfg_ready = (r_state != RUN);

endmodule

// File: tb/tb_force_window_sched.sv
// Directed plus random bench for force_window_sched against a window-list
// reference model (narrow counter so saturation is reachable).
module tb_force_window_sched;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int CW   = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          cfg_valid = 0, cfg_ready;
  logic [1:0]    cfg_idx = 0;
  logic [CW-1:0] cfg_start = 0, cfg_len = 0;
  logic [W-1:0]  cfg_mask = 0, cfg_value = 0;
  logic          run = 0, abort = 0;
  logic [CW-1:0] stop_cyc = 0;
  logic [W-1:0]  net_i = 0, net_o, force_en, force_val;
  logic [CW-1:0] cyc;
  logic          busy, done;

  force_window_sched #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_mask(cfg_mask), .cfg_value(cfg_value), .run(run), .abort(abort),
    .stop_cyc(stop_cyc), .net_i(net_i), .net_o(net_o), .force_en(force_en),
    .force_val(force_val), .cyc(cyc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: schedule as plain integer windows plus run/done flags.
  int           m_start[D], m_len[D];
  logic [W-1:0] m_mask[D], m_val[D];
  bit           m_run, m_done;
  int           m_cyc;
  int           n_cmp = 0, n_bad = 0;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_cyc = 0;
    for (int k = 0; k < D; k++) begin
      m_start[k] = 0; m_len[k] = 0; m_mask[k] = 0; m_val[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit pre_run = m_run;
    if (cfg_valid && !pre_run) begin
      m_start[cfg_idx] = int'(cfg_start);
      m_len[cfg_idx]   = int'(cfg_len);
      m_mask[cfg_idx]  = cfg_mask;
      m_val[cfg_idx]   = cfg_value;
    end
    if (abort) begin
      m_run = 0; m_done = 0;
    end else if (!pre_run) begin
      if (run) begin m_run = 1; m_done = 0; m_cyc = 0; end
    end else if (m_cyc == int'(stop_cyc)) begin
      m_run = 0; m_done = 1;
    end else if (m_cyc != CMAX) begin
      m_cyc++;
    end
  endtask

  task automatic model_force(output logic [W-1:0] en, output logic [W-1:0] val);
    en = 0; val = 0;
    if (m_run) begin
      for (int b = 0; b < W; b++) begin
        bit found = 0;
        for (int k = D - 1; k >= 0; k--) begin
          if (!found && m_len[k] != 0 && m_cyc >= m_start[k] &&
              m_cyc < m_start[k] + m_len[k] && m_mask[k][b]) begin
            found = 1; en[b] = 1'b1; val[b] = m_val[k][b];
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (model cyc %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] een, evl;
    model_force(een, evl);
    chk("cyc", 32'(cyc), 32'(m_cyc));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_run));
    chk("force_en", 32'(force_en), 32'(een));
    chk("force_val", 32'(force_val), 32'(evl));
    chk("net_o", 32'(net_o), 32'((een & evl) | (~een & net_i)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    run = 0; abort = 0; cfg_valid = 0;
    net_i = W'($urandom);
    #1;
    check_all();
  endtask

  task automatic prog(input int idx, input int st, input int ln,
                      input logic [W-1:0] mk, input logic [W-1:0] vl);
    cfg_valid = 1; cfg_idx = 2'(idx); cfg_start = CW'(st); cfg_len = CW'(ln);
    cfg_mask = mk; cfg_value = vl;
    step();
  endtask

  task automatic clear_all();
    for (int k = 0; k < D; k++) prog(k, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic go(input int stp, input int n);
    stop_cyc = CW'(stp); run = 1;
    step();
    repeat (n) step();
  endtask

  initial begin
    model_reset();
    net_i = 8'h3c;
    #2;
    check_all();
    #10 rst_n = 1;

    // single window at cyc 4
    prog(0, 4, 1, 8'hff, 8'h5f);
    go(20, 24);

    // adjacent windows
    prog(0, 4, 2, 8'hff, 8'h5f);
    prog(1, 6, 2, 8'hff, 8'hf5);
    go(20, 24);

    // per-bit overlap, higher index supplies the low nibble
    clear_all();
    prog(0, 10, 4, 8'hff, 8'h5a);
    prog(1, 12, 2, 8'h0f, 8'h05);
    go(20, 24);

    // abort mid-window, with an ignored write during RUN
    clear_all();
    prog(0, 4, 3, 8'hff, 8'haa);
    go(20, 2);
    cfg_valid = 1; cfg_idx = 0; cfg_start = 0; cfg_len = 10; cfg_mask = 8'hff; cfg_value = 8'h11;
    step();
    repeat (2) step();
    abort = 1;
    step();
    repeat (3) step();
    go(20, 24);

    // run and abort together stays idle
    run = 1; abort = 1;
    step();
    step();

    // async reset mid-window, then rerun with lost schedule
    clear_all();
    prog(0, 2, 5, 8'hff, 8'hc3);
    go(30, 3);
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1;
    go(12, 16);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      if (cfg_valid) begin
        cfg_idx   = 2'($urandom_range(0, 3));
        cfg_start = CW'($urandom_range(0, 30));
        cfg_len   = CW'($urandom_range(0, 6));
        cfg_mask  = W'($urandom);
        cfg_value = W'($urandom);
      end
      run   = !cfg_valid && ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if (!m_run && $urandom_range(0, 3) == 0) stop_cyc = CW'($urandom_range(5, 40));
      step();
    end
    abort = 1;
    step();

    // len=0 entry never forces; window past all-ones holds through saturation
    clear_all();
    prog(0, 0, 0, 8'hff, 8'hff);
    prog(1, CMAX - 1, 10, 8'hff, 8'h3c);
    go(CMAX, CMAX + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
